mux_bus_arbiter: RTL

MUX_BUS_ARBITER -- requirements
Module: mux_bus_arbiter

---
 rtl/arb_pkg.sv | 22 ++
 rtl/arb_data_mux.sv | 13 +
 rtl/mux_bus_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the two-requester bus arbiter: state encodings,
// owner encoding, default parameters and the tie-break helper.
package arb_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE  = 2'd0;
    localparam arb_state_t ST_OWN_A = 2'd1;
    localparam arb_state_t ST_OWN_B = 2'd2;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_MAX_HOLD = 16;

    // A tie goes to whichever requester did not own the bus most recently.
    function automatic arb_state_t tie_winner(input logic last_owner);
        return (last_owner == OWNER_B) ? ST_OWN_A : ST_OWN_B;
    endfunction

endpackage

// File: rtl/arb_data_mux.sv
// WIDTH-parameterised 2:1 data mux; sel=0 picks in_a, sel=1 picks in_b.
module arb_data_mux #(
    parameter int WIDTH = 8
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] out
);

    assign out = sel ? in_b : in_a;

endmodule

// File: rtl/mux_bus_arbiter.sv
// Two-requester round-robin bus arbiter with registered grants, select and bus data.
// Optional hold-timeout preemption is built when ARB_TIMEOUT_EN is defined.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_IDLE  | no owner; bus_data holds, bus_valid low
// ST_OWN_A | requester A owns the bus, gnt_a high, sel=0
// ST_OWN_B | requester B owns the bus, gnt_b high, sel=1
module mux_bus_arbiter
    import arb_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             sel,
    output logic [WIDTH-1:0] bus_data,
    output logic             bus_valid
);

    arb_state_t       state;
    arb_state_t       state_next;
    logic             last_owner;
    logic             sel_next;
    logic             preempt_a;
    logic             preempt_b;
    logic [WIDTH-1:0] mux_data;

`ifdef ARB_TIMEOUT_EN
    localparam int         CW        = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

    logic [CW-1:0] hold_cnt;
    logic          hold_expired;

    assign hold_expired = (hold_cnt == HOLD_LAST);
    assign preempt_a    = hold_expired & req_b;
    assign preempt_b    = hold_expired & req_a;

    // Saturates at HOLD_LAST so an uncontested owner keeps the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if ((state_next != state) || (state_next == ST_IDLE)) begin
            hold_cnt <= '0;
        end else if (!hold_expired) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    localparam int unused_max_hold = MAX_HOLD;

    assign preempt_a = 1'b0;
    assign preempt_b = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (req_a && req_b) begin
                    state_next = tie_winner(last_owner);
                end else if (req_a) begin
                    state_next = ST_OWN_A;
                end else if (req_b) begin
                    state_next = ST_OWN_B;
                end
            end
            ST_OWN_A: begin
                if (!req_a || preempt_a) begin
                    state_next = req_b ? ST_OWN_B : ST_IDLE;
                end
            end
            ST_OWN_B: begin
                if (!req_b || preempt_b) begin
                    state_next = req_a ? ST_OWN_A : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_next = sel;
        if (state_next == ST_OWN_A) begin
            sel_next = 1'b0;
        end else if (state_next == ST_OWN_B) begin
            sel_next = 1'b1;
        end
    end

    // Mux is steered by the next-state select so data lines up with the grant.
    arb_data_mux #(
        .WIDTH (WIDTH)
    ) u_data_mux (
        .sel  (sel_next),
        .in_a (data_a),
        .in_b (data_b),
        .out  (mux_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_owner <= OWNER_B;
            gnt_a      <= 1'b0;
            gnt_b      <= 1'b0;
            sel        <= 1'b0;
            bus_data   <= '0;
            bus_valid  <= 1'b0;
        end else begin
            state     <= state_next;
            gnt_a     <= (state_next == ST_OWN_A);
            gnt_b     <= (state_next == ST_OWN_B);
            sel       <= sel_next;
            bus_valid <= (state_next != ST_IDLE);
            if (state_next != ST_IDLE) begin
                last_owner <= (state_next == ST_OWN_B) ? OWNER_B : OWNER_A;
                bus_data   <= mux_data;
            end
        end
    end

endmodule
